fifo_rd_streamer: RTL

Read-side drain engine for the dual-clock FIFO. It runs entirely in the read clock domain and pops entries from the block-RAM storage through the read-pointer logic's enable/empty pair. It absorbs the fixed RAM read latency with a small credit-controlled output buffer. It presents the data as an AXI-Stream-style master (valid/ready) to the Ethernet datapath, sustaining one word per cycle with no loss under arbitrary backpressure.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_rd_outbuf.sv | 79 +++++++
 rtl/fifo_rd_streamer.sv | 94 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and helpers for the dual-clock FIFO blocks.
//   STORAGE_READ_LATENCY : read latency of the pipelined block-RAM storage;
//                          the read-side streamer defaults to this value.
//   READ_LATENCY_MIN/MAX : legal read-latency range for the drain engine.
//   cnt_bits(depth)      : width of a counter that must hold 0..depth.
package fifo_pkg;

    localparam int STORAGE_READ_LATENCY = 2;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;

    // A counter for 0..depth needs to represent depth itself, hence depth+1.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_outbuf.sv
// fifo_rd_outbuf
// Circular output buffer that sits between the storage read port and the
// stream interface of the read-side drain engine.
// Ports:
//   i_clk, i_reset_n : clock and synchronous active-low reset
//   i_push, i_push_data : write one entry at the tail
//   i_pop               : retire the entry at the head
//   o_head_data         : entry at the head (registered storage)
//   o_count             : current occupancy 0..DEPTH
//   o_not_empty         : occupancy is non-zero
module fifo_rd_outbuf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3,
    parameter int CNT_BITS   = cnt_bits(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [CNT_BITS-1:0]   o_count,
    output logic                  o_not_empty
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]   head_ptr;
    logic [PTR_BITS-1:0]   tail_ptr;
    logic [CNT_BITS-1:0]   count;

    // Explicit compare-and-clear so the pointers wrap correctly even when
    // DEPTH is not a power of two.
    function automatic logic [PTR_BITS-1:0] next_ptr(input logic [PTR_BITS-1:0] ptr);
        return (ptr == PTR_BITS'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Storage, pointers and occupancy. The storage is cleared on reset so the
    // head word reads as zero while the buffer is held in reset. A push and a
    // pop in the same cycle move both pointers and leave the count alone.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                mem[tail_ptr] <= i_push_data;
                tail_ptr      <= next_ptr(tail_ptr);
            end
            if (i_pop) begin
                head_ptr <= next_ptr(head_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_head_data = mem[head_ptr];
    assign o_count     = count;
    assign o_not_empty = (count != '0);

`ifndef SYNTHESIS
    // The credit scheme upstream reserves a slot for every popped word, so a
    // push into a full buffer without a matching pop means that scheme broke.
    overflow_check : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(i_push && !i_pop && (count == CNT_BITS'(DEPTH))));
`endif

endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer
// Read-side drain engine of the dual-clock FIFO. Pops storage entries through
// the read-pointer enable/empty pair, absorbs the fixed storage read latency
// with a credit-controlled output buffer and presents the words as a
// valid/ready stream master.
// Ports:
//   i_clk, i_reset_n : read clock, synchronous active-low reset
//   i_empty          : FIFO empty flag from the read-pointer logic
//   o_rd_en          : pop request / storage read enable
//   i_rd_data        : storage data, READ_LATENCY cycles after a pop
//   o_m_tdata/o_m_tvalid/i_m_tready : stream master interface
//   o_buf_count      : output buffer occupancy for debug counters
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = STORAGE_READ_LATENCY,
    parameter int BUF_DEPTH    = READ_LATENCY + 1,
    parameter int CNT_BITS     = cnt_bits(BUF_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_empty,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_m_tdata,
    output logic                  o_m_tvalid,
    input  logic                  i_m_tready,
    output logic [CNT_BITS-1:0]   o_buf_count
);

    // Reject parameter sets the credit scheme cannot support.
    if ((READ_LATENCY < READ_LATENCY_MIN) || (READ_LATENCY > READ_LATENCY_MAX)) begin : g_bad_latency
        $error("fifo_rd_streamer: READ_LATENCY out of range");
    end
    if (BUF_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
        $error("fifo_rd_streamer: BUF_DEPTH must be at least READ_LATENCY+1");
    end

    logic [READ_LATENCY-1:0] pop_flags;
    logic [CNT_BITS-1:0]     inflight;
    logic [CNT_BITS:0]       committed;
    logic                    pop;
    logic                    capture;
    logic                    handshake;

    assign handshake = o_m_tvalid && i_m_tready;
    assign committed = {1'b0, o_buf_count} + {1'b0, inflight};

    // credit = BUF_DEPTH - committed + handshake. Since committed never
    // exceeds BUF_DEPTH, credit > 0 reduces to "a slot is free, or one is
    // being freed by this cycle's handshake". Reset gates the enable so no
    // pop is issued while the pointer logic is being reset alongside us.
    assign o_rd_en = i_reset_n && !i_empty
                     && ((committed < (CNT_BITS + 1)'(BUF_DEPTH)) || handshake);
    assign pop     = o_rd_en && !i_empty;
    assign capture = pop_flags[READ_LATENCY-1];

    // In-flight tracker: one flag per pop marches down the shift register and
    // arrives at the top bit in the cycle its data is on i_rd_data. The
    // counter mirrors the number of set flags so the credit does not need a
    // popcount.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pop_flags <= '0;
            inflight  <= '0;
        end else begin
            pop_flags <= (pop_flags << 1) | READ_LATENCY'(pop);
            inflight  <= inflight + CNT_BITS'(pop) - CNT_BITS'(capture);
        end
    end

    fifo_rd_outbuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .CNT_BITS   (CNT_BITS)
    ) u_outbuf (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (capture),
        .i_push_data (i_rd_data),
        .i_pop       (handshake),
        .o_head_data (o_m_tdata),
        .o_count     (o_buf_count),
        .o_not_empty (o_m_tvalid)
    );

`ifndef SYNTHESIS
    // Every reserved slot must still fit in the buffer.
    credit_check : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        committed <= (CNT_BITS + 1)'(BUF_DEPTH));
`endif

endmodule
